// File: rtl/dly_line_prog.sv
// Programmable-depth clocked delay line: Z is I delayed by SEL+1 cycles, qualified by VALID.
// Optional macro DLY_LINE_EDGE_DET_EN adds per-bit RISE/FALL pulse outputs.
module dly_line_prog #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8,
  localparam int SELW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RN,
  input  logic             CE,
  input  logic [WIDTH-1:0] I,
  input  logic [SELW-1:0]  SEL,
  output logic [WIDTH-1:0] Z,
  output logic             VALID
`ifdef DLY_LINE_EDGE_DET_EN
  ,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [SELW-1:0] MAX_SEL = SELW'(DEPTH - 1);
  localparam logic [CW-1:0]   FULL    = CW'(DEPTH);
  localparam logic [CW-1:0]   INC     = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW:0]     ONE     = {{CW{1'b0}}, 1'b1};

  localparam logic [1:0] FILL   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] SWITCH = 2'd2;

  logic [WIDTH-1:0] stage [DEPTH];
  logic [WIDTH-1:0] z_hold;
  logic [SELW-1:0]  sel_q;
  logic [SELW-1:0]  sel_c;
  logic [CW-1:0]    fill_cnt;
  logic [CW-1:0]    fill_nxt;
  logic [CW:0]      fill_ext;
  logic [1:0]       state;

  function automatic logic [SELW-1:0] clamp_sel(input logic [SELW-1:0] s);
    return (s > MAX_SEL) ? MAX_SEL : s;
  endfunction

  // History depth (in CE edges) needed before a given select produces valid data.
  function automatic logic [CW:0] need_fill(input logic [SELW-1:0] s);
    return {{(CW + 1 - SELW){1'b0}}, s} + ONE;
  endfunction

  always_comb begin
    sel_c    = clamp_sel(SEL);
    fill_nxt = fill_cnt;
    if (CE && (fill_cnt != FULL))
      fill_nxt = fill_cnt + INC;
    fill_ext = {1'b0, fill_nxt};
  end

  always_comb begin
    VALID = (state == RUN);
    Z     = (state == RUN) ? stage[sel_q] : z_hold;
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      for (int k = 0; k < DEPTH; k++)
        stage[k] <= '0;
      z_hold   <= '0;
      sel_q    <= '0;
      fill_cnt <= '0;
      state    <= FILL;
    end else begin
      if (CE) begin
        stage[0] <= I;
        for (int k = 1; k < DEPTH; k++)
          stage[k] <= stage[k-1];
      end
      fill_cnt <= fill_nxt;
      if (state == RUN)
        z_hold <= Z;
      case (state)
        FILL: begin
          if (sel_c != sel_q)
            sel_q <= sel_c;
          else if (fill_ext >= need_fill(sel_q))
            state <= RUN;
        end
        RUN: begin
          // A select change costs one hold cycle if history suffices, else a refill.
          if (sel_c != sel_q) begin
            sel_q <= sel_c;
            state <= (fill_ext >= need_fill(sel_c)) ? SWITCH : FILL;
          end
        end
        SWITCH: state <= RUN;
        default: state <= FILL;
      endcase
    end
  end

`ifdef DLY_LINE_EDGE_DET_EN
  logic [WIDTH-1:0] z_prev;

  always_ff @(posedge CLK) begin
    if (!RN)
      z_prev <= '0;
    else
      z_prev <= Z;
  end

  always_comb begin
    RISE = {WIDTH{VALID}} & Z & ~z_prev;
    FALL = {WIDTH{VALID}} & ~Z & z_prev;
  end
`else
  // Edge-detect outputs and their history register are not built.
`endif

endmodule

// File: tb/tb_dly_line_prog.sv
// Directed bench for dly_line_prog: vector table on an 8-deep byte line,
// plus a hand-written clamp/edge sequence on a 6-deep single-bit line.
module tb_dly_line_prog;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rn8 = 1'b0, ce8 = 1'b1;
  logic [2:0] sel8 = '0;
  logic [7:0] i8 = '0;
  logic [7:0] z8;
  logic       v8;

  logic       rn6 = 1'b0, ce6 = 1'b1;
  logic [2:0] sel6 = '0;
  logic [0:0] i6 = '0;
  logic [0:0] z6;
  logic       v6;

`ifdef DLY_LINE_EDGE_DET_EN
  logic [7:0] rise8, fall8;
  logic [0:0] rise6, fall6;
`endif

  dly_line_prog #(.WIDTH(8), .DEPTH(8)) u8 (
    .CLK(clk), .RN(rn8), .CE(ce8), .I(i8), .SEL(sel8), .Z(z8), .VALID(v8)
`ifdef DLY_LINE_EDGE_DET_EN
    , .RISE(rise8), .FALL(fall8)
`endif
  );

  dly_line_prog #(.WIDTH(1), .DEPTH(6)) u6 (
    .CLK(clk), .RN(rn6), .CE(ce6), .I(i6), .SEL(sel6), .Z(z6), .VALID(v6)
`ifdef DLY_LINE_EDGE_DET_EN
    , .RISE(rise6), .FALL(fall6)
`endif
  );

  typedef struct {
    logic       rn;
    logic       ce;
    logic [2:0] sel;
    logic [7:0] i;
    logic [7:0] z;
    logic       v;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic rn, logic ce, logic [2:0] sel, logic [7:0] i,
                              logic [7:0] z, logic v);
    vec_t r;
    r.rn = rn; r.ce = ce; r.sel = sel; r.i = i; r.z = z; r.v = v;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step6(input int idx, input logic rn, input logic [2:0] sel,
                       input logic i, input logic ez, input logic ev,
                       input logic er, input logic ef);
    rn6 = rn; sel6 = sel; i6 = i;
    @(posedge clk); #1;
    chk("z6", idx, {7'd0, z6}, {7'd0, ez});
    chk("valid6", idx, {7'd0, v6}, {7'd0, ev});
`ifdef DLY_LINE_EDGE_DET_EN
    chk("rise6", idx, {7'd0, rise6}, {7'd0, er});
    chk("fall6", idx, {7'd0, fall6}, {7'd0, ef});
`else
    if (er === 1'bx || ef === 1'bx) $display("note: undefined edge expectation at %0d", idx);
`endif
  endtask

  initial begin
    // Reset held two edges, then SEL=0 valid after first edge
    tbl.push_back(mk(0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(1, 1, 0, 5, 5, 1));
    tbl.push_back(mk(1, 1, 0, 6, 6, 1));
    // Latency ramp at SEL=3
    tbl.push_back(mk(0, 1, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 3, 1, 0, 0));
    tbl.push_back(mk(1, 1, 3, 2, 0, 0));
    tbl.push_back(mk(1, 1, 3, 3, 0, 0));
    tbl.push_back(mk(1, 1, 3, 4, 1, 1));
    tbl.push_back(mk(1, 1, 3, 5, 2, 1));
    tbl.push_back(mk(1, 1, 3, 6, 3, 1));
    tbl.push_back(mk(1, 1, 3, 7, 4, 1));
    tbl.push_back(mk(1, 1, 3, 8, 5, 1));
    // SEL changes with full history: one hold cycle each
    tbl.push_back(mk(1, 1, 2, 9, 5, 0));
    tbl.push_back(mk(1, 1, 2, 10, 8, 1));
    tbl.push_back(mk(1, 1, 5, 11, 8, 0));
    tbl.push_back(mk(1, 1, 5, 12, 7, 1));
    tbl.push_back(mk(1, 1, 5, 13, 8, 1));
    // Insufficient history: SEL=7 after two edges forces refill
    tbl.push_back(mk(0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 21, 21, 1));
    tbl.push_back(mk(1, 1, 0, 22, 22, 1));
    tbl.push_back(mk(1, 1, 7, 23, 22, 0));
    tbl.push_back(mk(1, 1, 7, 24, 22, 0));
    tbl.push_back(mk(1, 1, 7, 25, 22, 0));
    tbl.push_back(mk(1, 1, 7, 26, 22, 0));
    tbl.push_back(mk(1, 1, 7, 27, 22, 0));
    tbl.push_back(mk(1, 1, 7, 28, 21, 1));
    tbl.push_back(mk(1, 1, 7, 29, 22, 1));
    // CE low in RUN: output frozen, still valid
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(1, 0, 7, 8'(50 + k), 22, 1));
    tbl.push_back(mk(1, 1, 7, 30, 23, 1));
    // CE low in FILL: fill count and stages frozen
    tbl.push_back(mk(0, 1, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 2, 40, 0, 0));
    tbl.push_back(mk(1, 1, 2, 41, 0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1, 0, 2, 99, 0, 0));
    tbl.push_back(mk(1, 1, 2, 42, 40, 1));
    tbl.push_back(mk(1, 1, 2, 43, 41, 1));

    for (int n = 0; n < tbl.size(); n++) begin
      rn8 = tbl[n].rn; ce8 = tbl[n].ce; sel8 = tbl[n].sel; i8 = tbl[n].i;
      @(posedge clk); #1;
      chk("z8", n, z8, tbl[n].z);
      chk("valid8", n, {7'd0, v8}, {7'd0, tbl[n].v});
    end

    // DEPTH=6 line, SEL=7 clamps to delay 6; a two-cycle high pulse on I
    step6(0, 0, 7, 0, 0, 0, 0, 0);
    step6(1, 1, 7, 1, 0, 0, 0, 0);
    step6(2, 1, 7, 1, 0, 0, 0, 0);
    step6(3, 1, 7, 0, 0, 0, 0, 0);
    step6(4, 1, 7, 0, 0, 0, 0, 0);
    step6(5, 1, 7, 0, 0, 0, 0, 0);
    step6(6, 1, 7, 0, 1, 1, 1, 0);
    step6(7, 1, 7, 0, 1, 1, 0, 0);
    step6(8, 1, 7, 0, 0, 1, 0, 1);
    step6(9, 1, 7, 0, 0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
